bcd_counter_multi: RTL and testbench

//  Parametrised multi-digit BCD up/down counter with parallel load and terminal-count output.

---
 rtl/bcd_counter_multi_if.sv | 23 ++
 rtl/bcd_counter_multi.sv | 83 ++++++++
 tb/tb_bcd_counter_multi.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_multi_if.sv
// Handshake bundle for bcd_counter_multi: count controls, load path and status.
// The master modport drives the controls; the slave modport is the counter side.
interface bcd_counter_multi_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   Q;
  logic                  done;
  logic                  ovf;

  modport master (
    output enable, up_down, load, load_value,
    input  Q, done, ovf
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output Q, done, ovf
  );
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-decade BCD up/down counter with clamped parallel load, combinational terminal count and sticky ovf.
// Define BCD_CNT_SATURATE_EN to hold at the terminal state instead of wrapping.
module bcd_counter_multi #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  bcd_counter_multi_if.slave bus
);

  logic [4*DIGITS-1:0] countQ, countD;
  logic                ovfQ, ovfD;
  logic [4*DIGITS-1:0] stepValue;
  logic [4*DIGITS-1:0] loadClamped;
  logic                allNine, allZero, terminal;
  logic                chain;
  logic [3:0]          digit;

  // Ripple carry/borrow across decades: a digit moves only when every lower digit is at its limit.
  always_comb begin
    allNine     = 1'b1;
    allZero     = 1'b1;
    chain       = 1'b1;
    digit       = 4'd0;
    stepValue   = countQ;
    loadClamped = bus.load_value;
    for (int i = 0; i < DIGITS; i++) begin
      digit   = countQ[4*i +: 4];
      allNine = allNine & (digit == 4'd9);
      allZero = allZero & (digit == 4'd0);
      if (chain) begin
        if (bus.up_down) begin
          stepValue[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
          stepValue[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
      end
      chain = chain & (bus.up_down ? (digit == 4'd9) : (digit == 4'd0));
      if (bus.load_value[4*i +: 4] > 4'd9) begin
        loadClamped[4*i +: 4] = 4'd9;
      end
    end
    terminal = bus.up_down ? allNine : allZero;
  end

  always_comb begin
    countD = countQ;
    ovfD   = ovfQ;
    if (bus.load) begin
      countD = loadClamped;
      ovfD   = 1'b0;
    end else if (bus.enable) begin
`ifdef BCD_CNT_SATURATE_EN
      if (terminal) begin
        ovfD = 1'b1;
      end else begin
        countD = stepValue;
      end
`else
      countD = stepValue;
      if (terminal) begin
        ovfD = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      countQ <= '0;
      ovfQ   <= 1'b0;
    end else begin
      countQ <= countD;
      ovfQ   <= ovfD;
    end
  end

  // done feeds the next cascaded stage, so it must see the terminal state without a register delay.
  assign bus.done = bus.enable & ~bus.load & ~reset & terminal;
  assign bus.Q    = countQ;
  assign bus.ovf  = ovfQ;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench for bcd_counter_multi: a 4-digit and a 1-digit instance against an integer model.
module tb_bcd_counter_multi;

  logic clk;
  logic reset;
  int   nCmp;
  int   nFail;
  int   mVal;
  bit   mOvf;
  bit   doneObs;
  bit   doneExp;

  bcd_counter_multi_if #(.DIGITS(4)) bus4 ();
  bcd_counter_multi_if #(.DIGITS(1)) bus1 ();

  bcd_counter_multi #(.DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  bcd_counter_multi #(.DIGITS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clampVal(input logic [15:0] lv);
    int v;
    int w;
    int nib;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      nib = int'(lv[4*i +: 4]);
      v = v + ((nib > 9) ? 9 : nib) * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Drives one cycle on the 4-digit instance (called at negedge), captures done, advances the model.
  task automatic cycle(input bit rst, input bit ld, input bit en, input bit ud, input logic [15:0] lv);
    reset           = rst;
    bus4.load       = ld;
    bus4.enable     = en;
    bus4.up_down    = ud;
    bus4.load_value = lv;
    #1;
    doneObs = bus4.done;
    doneExp = en && !ld && !rst && (ud ? (mVal == 9999) : (mVal == 0));
    @(posedge clk);
    if (rst) begin
      mVal = 0;
      mOvf = 1'b0;
    end else if (ld) begin
      mVal = clampVal(lv);
      mOvf = 1'b0;
    end else if (en) begin
      if (ud && mVal == 9999) begin
        mOvf = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
        mVal = 0;
`endif
      end else if (!ud && mVal == 0) begin
        mOvf = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
        mVal = 9999;
`endif
      end else begin
        mVal = ud ? mVal + 1 : mVal - 1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    nCmp++;
    if (bus4.Q !== 16'h0000) begin
      nFail++;
      $display("FAIL reset_q: got %h expected 0000", bus4.Q);
    end
    nCmp++;
    if (bus4.ovf !== 1'b0) begin
      nFail++;
      $display("FAIL reset_ovf: got %b expected 0", bus4.ovf);
    end
    nCmp++;
    if (doneObs !== 1'b0) begin
      nFail++;
      $display("FAIL reset_done: got %b expected 0", doneObs);
    end
    nCmp++;
    if (bus1.Q !== 4'h0) begin
      nFail++;
      $display("FAIL reset_q1: got %h expected 0", bus1.Q);
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      nCmp++;
      if (doneObs !== doneExp) begin
        nFail++;
        $display("FAIL count_up_done: step %0d got %b expected %b", i, doneObs, doneExp);
      end
    end
    nCmp++;
    if (bus4.Q !== 16'h0010) begin
      nFail++;
      $display("FAIL count_up_q: got %h expected 0010", bus4.Q);
    end
    nCmp++;
    if (bus4.ovf !== 1'b0) begin
      nFail++;
      $display("FAIL count_up_ovf: got %b expected 0", bus4.ovf);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
    nCmp++;
    if (bus4.Q !== 16'h9998) begin
      nFail++;
      $display("FAIL wrap_load: got %h expected 9998", bus4.Q);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    nCmp++;
    if (bus4.Q !== 16'h9999 || doneObs !== 1'b0) begin
      nFail++;
      $display("FAIL wrap_step1: got q=%h done=%b expected q=9999 done=0", bus4.Q, doneObs);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    nCmp++;
    if (doneObs !== 1'b1) begin
      nFail++;
      $display("FAIL wrap_done: got %b expected 1", doneObs);
    end
    nCmp++;
`ifdef BCD_CNT_SATURATE_EN
    if (bus4.Q !== 16'h9999 || bus4.ovf !== 1'b1) begin
      nFail++;
      $display("FAIL wrap_sat: got q=%h ovf=%b expected q=9999 ovf=1", bus4.Q, bus4.ovf);
    end
`else
    if (bus4.Q !== 16'h0000 || bus4.ovf !== 1'b1) begin
      nFail++;
      $display("FAIL wrap_up: got q=%h ovf=%b expected q=0000 ovf=1", bus4.Q, bus4.ovf);
    end
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    nCmp++;
    if (bus4.ovf !== 1'b1 || doneObs !== 1'b0 || bus4.Q !== toBcd(mVal)) begin
      nFail++;
      $display("FAIL wrap_hold: got q=%h ovf=%b done=%b expected q=%h ovf=1 done=0",
               bus4.Q, bus4.ovf, doneObs, toBcd(mVal));
    end
  endtask

  task automatic test_borrow();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    nCmp++;
    if (bus4.Q !== 16'h0099 || bus4.ovf !== 1'b0) begin
      nFail++;
      $display("FAIL borrow: got q=%h ovf=%b expected q=0099 ovf=0", bus4.Q, bus4.ovf);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    nCmp++;
    if (doneObs !== 1'b1) begin
      nFail++;
      $display("FAIL borrow_done: got %b expected 1", doneObs);
    end
    nCmp++;
`ifdef BCD_CNT_SATURATE_EN
    if (bus4.Q !== 16'h0000 || bus4.ovf !== 1'b1) begin
      nFail++;
      $display("FAIL borrow_sat: got q=%h ovf=%b expected q=0000 ovf=1", bus4.Q, bus4.ovf);
    end
`else
    if (bus4.Q !== 16'h9999 || bus4.ovf !== 1'b1) begin
      nFail++;
      $display("FAIL borrow_wrap: got q=%h ovf=%b expected q=9999 ovf=1", bus4.Q, bus4.ovf);
    end
`endif
  endtask

  task automatic test_clamp_load();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'hA3F5);
    nCmp++;
    if (bus4.Q !== 16'h9395 || bus4.ovf !== 1'b0 || doneObs !== 1'b0) begin
      nFail++;
      $display("FAIL clamp_load: got q=%h ovf=%b done=%b expected q=9395 ovf=0 done=0",
               bus4.Q, bus4.ovf, doneObs);
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0457);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    nCmp++;
    if (bus4.Q !== 16'h0000 || bus4.ovf !== 1'b0) begin
      nFail++;
      $display("FAIL reset_priority: got q=%h ovf=%b expected q=0000 ovf=0", bus4.Q, bus4.ovf);
    end
  endtask

  task automatic test_single_digit();
    int  s;
    bit  o;
    bit  d;
    s = 0;
    o = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus1.enable  = 1'b1;
      bus1.up_down = 1'b1;
      bus1.load    = 1'b0;
      #1;
      d = bus1.done;
      nCmp++;
      if (d !== (s == 9)) begin
        nFail++;
        $display("FAIL single_done: step %0d got %b expected %b", i, d, (s == 9));
      end
      @(posedge clk);
      if (s == 9) begin
        o = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
        s = 0;
`endif
      end else begin
        s = s + 1;
      end
      @(negedge clk);
      nCmp++;
      if (bus1.Q !== 4'(s) || bus1.ovf !== o) begin
        nFail++;
        $display("FAIL single_q: step %0d got q=%h ovf=%b expected q=%0d ovf=%b", i, bus1.Q, bus1.ovf, s, o);
      end
    end
    bus1.enable = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] lv;
    bit ld;
    bit en;
    bit ud;
    bit rst;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9990 | 16'($urandom_range(0, 9));
        default: lv = 16'($urandom);
      endcase
      rst = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = ($urandom_range(0, 1) == 1);
      cycle(rst, ld, en, ud, lv);
      nCmp++;
      if (bus4.Q !== toBcd(mVal) || bus4.ovf !== mOvf || doneObs !== doneExp) begin
        nFail++;
        $display("FAIL random: step %0d got q=%h ovf=%b done=%b expected q=%h ovf=%b done=%b",
                 i, bus4.Q, bus4.ovf, doneObs, toBcd(mVal), mOvf, doneExp);
      end
    end
  endtask

  initial begin
    nCmp = 0;
    nFail = 0;
    mVal = 0;
    mOvf = 1'b0;
    reset = 1'b1;
    bus4.enable = 1'b0;
    bus4.up_down = 1'b1;
    bus4.load = 1'b0;
    bus4.load_value = '0;
    bus1.enable = 1'b0;
    bus1.up_down = 1'b1;
    bus1.load = 1'b0;
    bus1.load_value = '0;
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap();
    test_borrow();
    test_clamp_load();
    test_reset_priority();
    test_single_digit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
